// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator for a 5-port mesh router.
// Define SA_FIXED_PRIO_EN for fixed priority (L highest, W lowest).
module switch_allocator #(
  parameter int N_PORT     = 5,
  parameter int N_REGISTER = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_PORT*N_REGISTER-1:0] req_dest,
  input  logic [N_PORT-1:0]            out_busy,
  output logic [N_PORT-1:0]            grant,
  output logic [N_PORT*N_REGISTER-1:0] out_sel,
  output logic [N_PORT-1:0]            out_vld
);

  localparam int W = N_REGISTER;
  localparam logic [W-1:0] SEL_IDLE = '1;

  logic [N_PORT-1:0][N_PORT-1:0] cand;
  logic [N_PORT-1:0]             win_vld;
  logic [N_PORT*W-1:0]           win_idx;
  logic [N_PORT-1:0]             nxt_grant;

  function automatic logic [W-1:0] wrap_add(
    input logic [W-1:0] base,
    input int           k
  );
    logic [W:0] s;
    s = {1'b0, base} + (W+1)'(k);
    if (s >= (W+1)'(N_PORT))
      s = s - (W+1)'(N_PORT);
    return s[W-1:0];
  endfunction

`ifndef SA_FIXED_PRIO_EN
  logic [N_PORT*W-1:0] ptr;
  logic [N_PORT*W-1:0] nxt_ptr;
`endif

  // A just-granted input still shows the flit being popped, so skip it.
  always_comb begin
    cand = '0;
    for (int o = 0; o < N_PORT; o++) begin
      for (int i = 0; i < N_PORT; i++) begin
        cand[o][i] = (req_dest[i*W +: W] == W'(o))
                   && !grant[i]
                   && !out_busy[o];
      end
    end
  end

  // Scan from the far end so the nearest candidate to start wins last.
  always_comb begin
    logic [W-1:0] start;
    logic [W-1:0] idx;
    start   = '0;
    idx     = '0;
    win_vld = '0;
    win_idx = {N_PORT{SEL_IDLE}};
    for (int o = 0; o < N_PORT; o++) begin
`ifdef SA_FIXED_PRIO_EN
      start = '0;
`else
      start = ptr[o*W +: W];
`endif
      for (int k = N_PORT - 1; k >= 0; k--) begin
        idx = wrap_add(start, k);
        if (cand[o][idx]) begin
          win_vld[o]        = 1'b1;
          win_idx[o*W +: W] = idx;
        end
      end
    end
  end

  always_comb begin
    nxt_grant = '0;
    for (int o = 0; o < N_PORT; o++) begin
      if (win_vld[o])
        nxt_grant[win_idx[o*W +: W]] = 1'b1;
    end
  end

`ifndef SA_FIXED_PRIO_EN
  always_comb begin
    nxt_ptr = ptr;
    for (int o = 0; o < N_PORT; o++) begin
      if (win_vld[o])
        nxt_ptr[o*W +: W] = wrap_add(win_idx[o*W +: W], 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else
      ptr <= nxt_ptr;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      grant   <= '0;
      out_sel <= {N_PORT{SEL_IDLE}};
      out_vld <= '0;
    end else begin
      grant   <= nxt_grant;
      out_sel <= win_idx;
      out_vld <= win_vld;
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed-vector bench for switch_allocator.
// Covers reset, rotation, backpressure, parallel grants, illegal codes.
module tb_switch_allocator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] req_dest = 15'h7fff;
  logic [4:0]  out_busy = 5'b0;
  logic [4:0]  grant;
  logic [14:0] out_sel;
  logic [4:0]  out_vld;

  int n_vec = 0;
  int n_err = 0;

  switch_allocator #(
    .N_PORT(5),
    .N_REGISTER(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_dest(req_dest),
    .out_busy(out_busy),
    .grant(grant),
    .out_sel(out_sel),
    .out_vld(out_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [14:0] req;
    logic [4:0]  busy;
    logic [4:0]  g;
    logic [14:0] sel;
    logic [4:0]  vld;
  } vec_t;

  vec_t vq[$];

  localparam logic [14:0] ALL7 = 15'h7fff;

  function automatic logic [14:0] pk(
    input int c0, input int c1, input int c2,
    input int c3, input int c4
  );
    return {3'(c4), 3'(c3), 3'(c2), 3'(c1), 3'(c0)};
  endfunction

  task automatic add(
    input logic r, input logic [14:0] q,
    input logic [4:0] b, input logic [4:0] g,
    input logic [14:0] s, input logic [4:0] v
  );
    vec_t e;
    e.rst = r; e.req = q; e.busy = b;
    e.g = g; e.sel = s; e.vld = v;
    vq.push_back(e);
  endtask

  task automatic chk(
    input string nm, input logic [4:0] g,
    input logic [14:0] s, input logic [4:0] v
  );
    n_vec++;
    if (grant !== g || out_sel !== s || out_vld !== v) begin
      n_err++;
      $display("FAIL %s: got grant=%b sel=%h vld=%b, want grant=%b sel=%h vld=%b",
               nm, grant, out_sel, out_vld, g, s, v);
    end
  endtask

  initial begin
    logic [14:0] rq;
    int lat;

    // reset, then L -> E
    add(1, pk(0,0,0,0,0), 0, 0, ALL7, 0);
    add(1, pk(0,0,0,0,0), 0, 0, ALL7, 0);
    add(0, pk(2,7,7,7,7), 0, 5'b00001, pk(7,7,0,7,7), 5'b00100);
    add(0, ALL7, 0, 0, ALL7, 0);
`ifndef SA_FIXED_PRIO_EN
    // N, S, W contend for L: rotate N, S, W, N
    rq = pk(7,0,7,0,0);
    add(0, rq, 0, 5'b00010, pk(1,7,7,7,7), 5'b00001);
    add(0, rq, 0, 5'b01000, pk(3,7,7,7,7), 5'b00001);
    add(0, rq, 0, 5'b10000, pk(4,7,7,7,7), 5'b00001);
    add(0, rq, 0, 5'b00010, pk(1,7,7,7,7), 5'b00001);
`else
    // L and S contend for W: L wins unless just granted
    rq = pk(4,7,7,4,7);
    add(0, rq, 0, 5'b00001, pk(7,7,7,7,0), 5'b10000);
    add(0, rq, 0, 5'b01000, pk(7,7,7,7,3), 5'b10000);
    add(0, rq, 0, 5'b00001, pk(7,7,7,7,0), 5'b10000);
    add(0, rq, 0, 5'b01000, pk(7,7,7,7,3), 5'b10000);
`endif
    add(0, ALL7, 0, 0, ALL7, 0);
    // E -> N blocked by busy for 4 cycles
    rq = pk(7,7,1,7,7);
    for (int k = 0; k < 4; k++)
      add(0, rq, 5'b00010, 0, ALL7, 0);
    add(0, rq, 0, 5'b00100, pk(7,2,7,7,7), 5'b00010);
    add(0, ALL7, 0, 0, ALL7, 0);
    // full parallel permutation, held for 3 cycles
    rq = pk(1,2,3,4,0);
    add(0, rq, 0, 5'b11111, pk(4,0,1,2,3), 5'b11111);
    add(0, rq, 0, 0, ALL7, 0);
    add(0, rq, 0, 5'b11111, pk(4,0,1,2,3), 5'b11111);
    // illegal code ignored
    add(0, pk(7,7,7,7,6), 0, 0, ALL7, 0);
    add(0, pk(3,7,7,7,6), 0, 5'b00001, pk(7,7,7,0,7), 5'b01000);
    // mid-op reset drops pending grant and clears pointers
    rq = pk(3,3,7,7,7);
    add(1, rq, 0, 0, ALL7, 0);
    add(0, rq, 0, 5'b00001, pk(7,7,7,0,7), 5'b01000);
    add(0, rq, 0, 5'b00010, pk(7,7,7,1,7), 5'b01000);
    add(0, rq, 0, 5'b00001, pk(7,7,7,0,7), 5'b01000);
    // request to own port
    add(0, pk(7,1,7,7,7), 0, 5'b00010, pk(7,1,7,7,7), 5'b00010);
    add(0, ALL7, 0, 0, ALL7, 0);

    foreach (vq[i]) begin
      @(negedge clk);
      rst      = vq[i].rst;
      req_dest = vq[i].req;
      out_busy = vq[i].busy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), vq[i].g, vq[i].sel, vq[i].vld);
    end

    // registered grant survives busy rising afterwards
    @(negedge clk);
    req_dest = pk(7,7,7,2,7);
    out_busy = 0;
    @(posedge clk);
    #1;
    chk("hold_grant", 5'b01000, pk(7,7,3,7,7), 5'b00100);
    @(negedge clk);
    req_dest = ALL7;
    out_busy = 5'b00100;
    #1;
    chk("hold_after_busy", 5'b01000, pk(7,7,3,7,7), 5'b00100);
    @(posedge clk);
    #1;
    chk("busy_idle", 0, ALL7, 0);

    // busy with request, then bounded wait for release grant
    @(negedge clk);
    req_dest = pk(7,7,1,7,7);
    out_busy = 5'b00010;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold%0d", k), 0, ALL7, 0);
    end
    @(negedge clk);
    out_busy = 0;
    lat = 0;
    while (lat < 4 && grant[2] !== 1'b1) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_vec++;
    if (lat != 1) begin
      n_err++;
      $display("FAIL bp_release: got latency=%0d, want 1", lat);
    end
    chk("bp_release_out", 5'b00100, pk(7,2,7,7,7), 5'b00010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Per-output round-robin arbiter that schedules the 5x5 crossbar switch of a mesh NoC router.
- Each of the 5 input blocks (L, N, E, S, W) presents a routed destination code each cycle.
- The allocator picks at most one winner per output port and drives the input grant pulses and the crossbar mux selects.
- It sits between the input blocks / output controllers and the switch datapath; output backpressure (full/ret) blocks allocation to that output.

Parameters:
- N_PORT, 5, number of router ports; index order 0=L, 1=N, 2=E, 3=S, 4=W (fixed at 5; the parameter is for readability only).
- N_REGISTER, 3, width of one destination/select code.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_dest  input  N_PORT*N_REGISTER  packed destination codes, slice i = input port i.
  - Codes 0..4 = requested output port.
  - Codes 5..7 = no request.
- out_busy  input  N_PORT  bit o = 1 when output o's downstream buffer is full (ret asserted); no allocation to o.
- grant  output  N_PORT  bit i = 1-cycle pulse; input i pops its head flit this cycle.
- out_sel  output  N_PORT*N_REGISTER  slice o = index of the input driving output o this cycle; 7 when idle.
- out_vld  output  N_PORT  bit o = 1 when output o carries a valid flit this cycle (drives val_out).

Behaviour:
- Reset (rst=1 at a rising edge):
  - grant=0, out_vld=0, every out_sel slice=7.
  - All round-robin pointers ptr[o]=0.
  - Reset takes effect mid-operation as well; any pending grant is dropped, with no partial state retained.
- Candidate rule (combinational, per cycle): input i is a candidate for output o when all of the following hold:
  - req_dest slice i == o;
  - grant[i]==0 (an input granted in the current cycle is excluded, since its request still shows the flit being popped);
  - out_busy[o]==0.
- Winner per output:
  - The first candidate found searching i = ptr[o], ptr[o]+1, ... modulo 5.
  - Each input requests exactly one output, so no input can win twice.
- Registered outputs (1-cycle latency from request to grant):
  - If output o has a winner w: next grant[w]=1, out_sel slice o = w, out_vld[o]=1, ptr[o] <= (w+1) mod 5 (wraps 4 -> 0).
  - If output o has no winner: out_vld[o]=0, out_sel slice o = 7, ptr[o] unchanged.
  - Inputs with no win get grant=0 next cycle.
- Throughput:
  - A single continuously requesting input gets a grant every other cycle (grant cycle excluded).
  - Two inputs contending for one output alternate and reach 1 grant/cycle combined.
- out_busy rising in the same cycle as a request: no grant issued; the request is held and re-arbitrated when busy falls.
  - A grant already registered is not cancelled by later busy.
- A request with an illegal code 5..7 is ignored; this is not an error.
- A request to its own port (e.g. N->N) is arbitrated normally; route legality is the input block's job.
- Five simultaneous requests to five distinct outputs: all five granted in the same cycle.

Optional Feature:
- Macro SA_FIXED_PRIO_EN.
- Defined:
  - Pointers are removed; the search always starts at i=0, so L has highest priority and W lowest.
  - Starvation is permitted; the mode is for debug and deterministic-latency tests.
- Undefined: round-robin as specified above (default build).

Test Plan:
- Reset check: hold rst=1 for 2 cycles with all req_dest=0 -> grant=00000, out_vld=00000, every out_sel=7. Release rst, L requests E (code 2) -> next cycle grant[0]=1, out_sel[E]=0, out_vld[2]=1.
- Round-robin fairness: N, S and W all request L continuously with out_busy=0 -> grants to L rotate N, S, W, N, ... with out_sel[L] = 1, 3, 4, 1. Pointer wraps after W. No input is granted in two consecutive cycles.
- Backpressure: E requests N with out_busy[1]=1 for 4 cycles -> no grant and out_vld[1]=0 throughout. Busy falls at cycle 4 -> grant[2]=1 one cycle later.
- Full parallel: L->N, N->E, E->S, S->W, W->L in the same cycle -> all five grant bits =1 next cycle, out_vld=11111, each out_sel matches its source.
- Illegal code and mid-op reset: W presents code 6 -> never granted. With grants pending, assert rst for 1 cycle -> all outputs cleared next cycle and ptr=0. The first arbitration after reset favours the lowest index.
- SA_FIXED_PRIO_EN build: L and S both hold requests to W -> L wins every eligible cycle. S is granted only in cycles where L is excluded (L was granted the previous cycle).
